// File: rtl/decode_stage_pipelined.sv
// RV32I decode stage: decodes the IF/ID instruction, reads the register file and
// registers fields, operands and a packed control word into the ID/EX register.
module decode_stage_pipelined #(
    parameter int XLEN      = 32,
    parameter int NREGS     = 32,
    parameter bit WB_BYPASS = 1'b1,
    parameter int CNT_W     = 16,
    localparam int AW       = $clog2(NREGS)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             if_valid,
    output logic             if_ready,
    input  logic [31:0]      if_instr,
    input  logic [XLEN-1:0]  if_pc,
    input  logic             id_flush,
    input  logic             wb_wr_en,
    input  logic [AW-1:0]    wb_wr_addr,
    input  logic [XLEN-1:0]  wb_wr_data,
    input  logic             ex_ready,
    output logic             ex_valid,
    output logic [XLEN-1:0]  ex_pc,
    output logic [AW-1:0]    ex_rd,
    output logic [AW-1:0]    ex_rs1,
    output logic [AW-1:0]    ex_rs2,
    output logic [XLEN-1:0]  ex_imm,
    output logic [XLEN-1:0]  ex_rs1_data,
    output logic [XLEN-1:0]  ex_rs2_data,
    output logic [19:0]      ex_ctrl,
    output logic [CNT_W-1:0] stall_cnt
);

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    logic [XLEN-1:0] regs [NREGS];

    logic [6:0]      opcode;
    logic [2:0]      funct3;
    logic [AW-1:0]   rd_a, rs1_a, rs2_a;
    logic [3:0]      alu_f;
    logic [2:0]      load_t;
    logic [31:0]     imm32;
    logic [19:0]     ctrl_d;
    logic            uses_rs1, uses_rs2;
    logic [XLEN-1:0] rs1_data, rs2_data;
    logic            hold, hazard;

    assign opcode = if_instr[6:0];
    assign funct3 = if_instr[14:12];
    assign rd_a   = AW'(if_instr[11:7]);
    assign rs1_a  = AW'(if_instr[19:15]);
    assign rs2_a  = AW'(if_instr[24:20]);

    always_comb begin
        // funct7[5] selects SUB only for R-type; SRA/SRAI share it in both formats
        unique case (funct3)
            3'b000:  alu_f = (if_instr[30] && opcode == OP_R) ? 4'd1 : 4'd0;
            3'b001:  alu_f = 4'd5;
            3'b010:  alu_f = 4'd8;
            3'b011:  alu_f = 4'd9;
            3'b100:  alu_f = 4'd4;
            3'b101:  alu_f = if_instr[30] ? 4'd7 : 4'd6;
            3'b110:  alu_f = 4'd3;
            default: alu_f = 4'd2;
        endcase
        case (funct3)
            3'b001:  load_t = 3'd1;
            3'b010:  load_t = 3'd2;
            3'b100:  load_t = 3'd3;
            3'b101:  load_t = 3'd4;
            default: load_t = 3'd0;
        endcase
    end

    always_comb begin
        ctrl_d   = '0;
        imm32    = '0;
        uses_rs1 = 1'b0;
        uses_rs2 = 1'b0;
        case (opcode)
            OP_R: begin
                ctrl_d[3:0] = alu_f;
                ctrl_d[12]  = 1'b1;
                uses_rs1    = 1'b1;
                uses_rs2    = 1'b1;
            end
            OP_IMM: begin
                ctrl_d[3:0] = alu_f;
                ctrl_d[4]   = 1'b1;
                ctrl_d[12]  = 1'b1;
                imm32       = {{20{if_instr[31]}}, if_instr[31:20]};
                uses_rs1    = 1'b1;
            end
            OP_LOAD: begin
                ctrl_d[4]   = 1'b1;
                ctrl_d[6]   = 1'b1;
                ctrl_d[9:7] = load_t;
                ctrl_d[12]  = 1'b1;
                ctrl_d[13]  = 1'b1;
                imm32       = {{20{if_instr[31]}}, if_instr[31:20]};
                uses_rs1    = 1'b1;
            end
            OP_STORE: begin
                ctrl_d[4]     = 1'b1;
                ctrl_d[5]     = 1'b1;
                ctrl_d[11:10] = funct3[1:0];
                imm32         = {{20{if_instr[31]}}, if_instr[31:25], if_instr[11:7]};
                uses_rs1      = 1'b1;
                uses_rs2      = 1'b1;
            end
            OP_BRANCH: begin
                ctrl_d[3:0] = 4'd1;
                ctrl_d[14]  = 1'b1;
                imm32       = {{19{if_instr[31]}}, if_instr[31], if_instr[7],
                               if_instr[30:25], if_instr[11:8], 1'b0};
                uses_rs1    = 1'b1;
                uses_rs2    = 1'b1;
            end
            OP_JAL: begin
                ctrl_d[12] = 1'b1;
                ctrl_d[15] = 1'b1;
                imm32      = {{11{if_instr[31]}}, if_instr[31], if_instr[19:12],
                              if_instr[20], if_instr[30:21], 1'b0};
            end
            OP_JALR: begin
                ctrl_d[4]  = 1'b1;
                ctrl_d[12] = 1'b1;
                ctrl_d[16] = 1'b1;
                imm32      = {{20{if_instr[31]}}, if_instr[31:20]};
                uses_rs1   = 1'b1;
            end
            OP_AUIPC: begin
                ctrl_d[12] = 1'b1;
                ctrl_d[17] = 1'b1;
                imm32      = {if_instr[31:12], 12'b0};
            end
            OP_LUI: begin
                ctrl_d[12] = 1'b1;
                ctrl_d[18] = 1'b1;
                imm32      = {if_instr[31:12], 12'b0};
            end
            default: ctrl_d[19] = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (wb_wr_en && wb_wr_addr != '0)
            regs[wb_wr_addr] <= wb_wr_data;
    end

    always_comb begin
        rs1_data = '0;
        rs2_data = '0;
        if (rs1_a != '0)
            rs1_data = (WB_BYPASS && wb_wr_en && wb_wr_addr == rs1_a) ? wb_wr_data : regs[rs1_a];
        if (rs2_a != '0)
            rs2_data = (WB_BYPASS && wb_wr_en && wb_wr_addr == rs2_a) ? wb_wr_data : regs[rs2_a];
    end

    assign hold   = ex_valid && !ex_ready;
    assign hazard = ex_valid && ex_ctrl[6] && ex_rd != '0 && if_valid &&
                    ((uses_rs1 && rs1_a == ex_rd) || (uses_rs2 && rs2_a == ex_rd));
    assign if_ready = id_flush || (!hold && !hazard);

    always_ff @(posedge clk) begin
        if (rst) begin
            ex_valid    <= 1'b0;
            ex_pc       <= '0;
            ex_rd       <= '0;
            ex_rs1      <= '0;
            ex_rs2      <= '0;
            ex_imm      <= '0;
            ex_rs1_data <= '0;
            ex_rs2_data <= '0;
            ex_ctrl     <= '0;
            stall_cnt   <= '0;
        end else if (id_flush) begin
            ex_valid <= 1'b0;
            ex_ctrl  <= '0;
        end else if (!hold) begin
            if (hazard) begin
                ex_valid <= 1'b0;
                ex_ctrl  <= '0;
                if (stall_cnt != '1)
                    stall_cnt <= stall_cnt + CNT_W'(1);
            end else if (if_valid) begin
                ex_valid    <= 1'b1;
                ex_pc       <= if_pc;
                ex_rd       <= rd_a;
                ex_rs1      <= rs1_a;
                ex_rs2      <= rs2_a;
                ex_imm      <= XLEN'($signed(imm32));
                ex_rs1_data <= rs1_data;
                ex_rs2_data <= rs2_data;
                ex_ctrl     <= ctrl_d;
            end else begin
                ex_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_decode_stage_pipelined.sv
// Bench for decode_stage_pipelined: directed scenarios plus random traffic checked
// against a cycle-level reference model of the decode/ID-EX behaviour.
module tb_decode_stage_pipelined;

    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          rst, if_valid, if_ready, id_flush, wb_wr_en, ex_ready, ex_valid;
    logic [31:0]   if_instr, if_pc, wb_wr_data, ex_pc, ex_imm, ex_rs1_data, ex_rs2_data;
    logic [4:0]    wb_wr_addr, ex_rd, ex_rs1, ex_rs2;
    logic [19:0]   ex_ctrl;
    logic [CW-1:0] stall_cnt;

    decode_stage_pipelined #(.XLEN(32), .NREGS(32), .WB_BYPASS(1'b1), .CNT_W(CW)) dut (
        .clk(clk), .rst(rst), .if_valid(if_valid), .if_ready(if_ready), .if_instr(if_instr),
        .if_pc(if_pc), .id_flush(id_flush), .wb_wr_en(wb_wr_en), .wb_wr_addr(wb_wr_addr),
        .wb_wr_data(wb_wr_data), .ex_ready(ex_ready), .ex_valid(ex_valid), .ex_pc(ex_pc),
        .ex_rd(ex_rd), .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_imm(ex_imm),
        .ex_rs1_data(ex_rs1_data), .ex_rs2_data(ex_rs2_data), .ex_ctrl(ex_ctrl),
        .stall_cnt(stall_cnt)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_err    = 0;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    typedef struct packed {
        logic [19:0] ctrl;
        logic [31:0] imm;
        logic        r1;
        logic        r2;
    } dec_t;

    // Reference decode straight from the RV32I field layouts and the ctrl bit map
    function automatic dec_t ref_decode(input logic [31:0] i);
        dec_t d;
        int unsigned f3 = 32'(i[14:12]);
        int unsigned alu_tab[8] = '{0, 5, 8, 9, 4, 6, 3, 2};
        logic [31:0] immi = $signed(i) >>> 20;
        d = '0;
        case (i[6:0])
            7'h33: begin
                d.ctrl[3:0] = 4'(alu_tab[f3] + (((f3 == 0 || f3 == 5) && i[30]) ? 1 : 0));
                d.ctrl[12] = 1'b1; d.r1 = 1'b1; d.r2 = 1'b1;
            end
            7'h13: begin
                d.ctrl[3:0] = 4'(alu_tab[f3] + ((f3 == 5 && i[30]) ? 1 : 0));
                d.ctrl[4] = 1'b1; d.ctrl[12] = 1'b1; d.r1 = 1'b1; d.imm = immi;
            end
            7'h03: begin
                d.ctrl[4] = 1'b1; d.ctrl[6] = 1'b1; d.ctrl[12] = 1'b1; d.ctrl[13] = 1'b1;
                d.ctrl[9:7] = 3'((f3 < 3) ? f3 : f3 - 1);
                d.r1 = 1'b1; d.imm = immi;
            end
            7'h23: begin
                d.ctrl[4] = 1'b1; d.ctrl[5] = 1'b1; d.ctrl[11:10] = 2'(f3);
                d.r1 = 1'b1; d.r2 = 1'b1; d.imm = {immi[31:5], i[11:7]};
            end
            7'h63: begin
                d.ctrl[3:0] = 4'd1; d.ctrl[14] = 1'b1; d.r1 = 1'b1; d.r2 = 1'b1;
                d.imm = {{20{i[31]}}, i[7], i[30:25], i[11:8], 1'b0};
            end
            7'h6F: begin
                d.ctrl[12] = 1'b1; d.ctrl[15] = 1'b1;
                d.imm = {{12{i[31]}}, i[19:12], i[20], i[30:21], 1'b0};
            end
            7'h67: begin
                d.ctrl[4] = 1'b1; d.ctrl[12] = 1'b1; d.ctrl[16] = 1'b1; d.r1 = 1'b1; d.imm = immi;
            end
            7'h17: begin d.ctrl[12] = 1'b1; d.ctrl[17] = 1'b1; d.imm = i & 32'hFFFF_F000; end
            7'h37: begin d.ctrl[12] = 1'b1; d.ctrl[18] = 1'b1; d.imm = i & 32'hFFFF_F000; end
            default: d.ctrl[19] = 1'b1;
        endcase
        return d;
    endfunction

    // Model state: ID/EX contents, stall counter and architectural registers
    logic        m_valid;
    logic [31:0] m_pc, m_imm, m_d1, m_d2;
    logic [4:0]  m_rd, m_rs1, m_rs2;
    logic [19:0] m_ctrl;
    int unsigned m_cnt;
    logic [31:0] rf [32];
    logic        consumed;

    function automatic logic [31:0] rf_read(input logic [4:0] a, input logic we,
                                            input logic [4:0] wa, input logic [31:0] wd);
        if (a == 0) return 32'h0;
        if (we && wa == a) return wd;
        return rf[a];
    endfunction

    task automatic step(input logic v, input logic [31:0] ins, input logic [31:0] pc,
                        input logic fl, input logic er, input logic we,
                        input logic [4:0] wa, input logic [31:0] wd, input logic r);
        dec_t d;
        logic hold, haz, exp_rdy;
        @(negedge clk);
        rst = r; if_valid = v; if_instr = ins; if_pc = pc; id_flush = fl; ex_ready = er;
        wb_wr_en = we; wb_wr_addr = wa; wb_wr_data = wd;
        #1;
        d    = ref_decode(ins);
        hold = m_valid && !er;
        haz  = m_valid && m_ctrl[6] && m_rd != 0 && v &&
               ((d.r1 && ins[19:15] == m_rd) || (d.r2 && ins[24:20] == m_rd));
        exp_rdy = fl || (!hold && !haz);
        check("if_ready", 32'(if_ready), 32'(exp_rdy));
        consumed = v && exp_rdy;
        if (r) begin
            m_valid = 0; m_pc = 0; m_rd = 0; m_rs1 = 0; m_rs2 = 0;
            m_imm = 0; m_d1 = 0; m_d2 = 0; m_ctrl = 0; m_cnt = 0;
        end else if (fl) begin
            m_valid = 0; m_ctrl = 0;
        end else if (!hold) begin
            if (haz) begin
                m_valid = 0; m_ctrl = 0;
                if (m_cnt < (1 << CW) - 1) m_cnt++;
            end else if (v) begin
                m_valid = 1; m_pc = pc; m_rd = ins[11:7]; m_rs1 = ins[19:15]; m_rs2 = ins[24:20];
                m_imm = d.imm; m_ctrl = d.ctrl;
                m_d1 = rf_read(ins[19:15], we, wa, wd);
                m_d2 = rf_read(ins[24:20], we, wa, wd);
            end else begin
                m_valid = 0;
            end
        end
        if (we && wa != 0) rf[wa] = wd;
        @(posedge clk);
        #1;
        check("ex_valid", 32'(ex_valid), 32'(m_valid));
        check("ex_pc", ex_pc, m_pc);
        check("ex_rd", 32'(ex_rd), 32'(m_rd));
        check("ex_rs1", 32'(ex_rs1), 32'(m_rs1));
        check("ex_rs2", 32'(ex_rs2), 32'(m_rs2));
        check("ex_imm", ex_imm, m_imm);
        check("ex_rs1_data", ex_rs1_data, m_d1);
        check("ex_rs2_data", ex_rs2_data, m_d2);
        check("ex_ctrl", 32'(ex_ctrl), 32'(m_ctrl));
        check("stall_cnt", 32'(stall_cnt), m_cnt);
    endtask

    function automatic logic [31:0] enc(input logic [6:0] f7, input logic [4:0] rs2,
                                        input logic [4:0] rs1, input logic [2:0] f3,
                                        input logic [4:0] rd, input logic [6:0] op);
        return {f7, rs2, rs1, f3, rd, op};
    endfunction

    logic [31:0] pc_ctr = 32'h1000;

    // Presents one instruction until accepted, bounded
    task automatic send(input logic [31:0] ins, input logic er);
        int tries = 0;
        consumed = 1'b0;
        while (!consumed && tries < 5) begin
            step(1'b1, ins, pc_ctr, 1'b0, er, 1'b0, 5'd0, 32'h0, 1'b0);
            tries++;
        end
        check("send_accepted", 32'(consumed), 32'd1);
        pc_ctr += 4;
    endtask

    task automatic idle(input logic er);
        step(1'b0, 32'h0, 32'h0, 1'b0, er, 1'b0, 5'd0, 32'h0, 1'b0);
    endtask

    function automatic logic [31:0] gen_instr();
        logic [4:0]  rd  = 5'($urandom_range(0, 7));
        logic [4:0]  rs1 = 5'($urandom_range(0, 7));
        logic [4:0]  rs2 = 5'($urandom_range(0, 7));
        logic [2:0]  f3  = 3'($urandom_range(0, 7));
        logic [31:0] rnd = $urandom;
        logic [2:0]  ld_f3 [5] = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5};
        logic [2:0]  br_f3 [6] = '{3'd0, 3'd1, 3'd4, 3'd5, 3'd6, 3'd7};
        logic [6:0]  bad_op [5] = '{7'h7F, 7'h00, 7'h5B, 7'h2B, 7'h77};
        logic [6:0]  f7;
        case ($urandom_range(0, 9))
            0: begin
                f7 = ((f3 == 0 || f3 == 5) && rnd[0]) ? 7'h20 : 7'h00;
                return enc(f7, rs2, rs1, f3, rd, 7'h33);
            end
            1: begin
                f7 = (f3 == 1) ? 7'h00 : (f3 == 5) ? (rnd[0] ? 7'h20 : 7'h00) : rnd[13:7];
                return enc(f7, rnd[24:20], rs1, f3, rd, 7'h13);
            end
            2, 3: return enc(rnd[13:7], rnd[24:20], rs1, ld_f3[$urandom_range(0, 4)], rd, 7'h03);
            4: return enc(rnd[13:7], rs2, rs1, 3'($urandom_range(0, 2)), rnd[4:0], 7'h23);
            5: return enc(rnd[13:7], rs2, rs1, br_f3[$urandom_range(0, 5)], rnd[4:0], 7'h63);
            6: return {rnd[31:12], rd, 7'h6F};
            7: return enc(rnd[13:7], rnd[24:20], rs1, 3'd0, rd, 7'h67);
            8: return {rnd[31:12], rd, rnd[0] ? 7'h37 : 7'h17};
            default: return {rnd[31:7], bad_op[$urandom_range(0, 4)]};
        endcase
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic        pv;
        logic [31:0] pins, ppc;
        m_valid = 0; m_pc = 0; m_rd = 0; m_rs1 = 0; m_rs2 = 0;
        m_imm = 0; m_d1 = 0; m_d2 = 0; m_ctrl = 0; m_cnt = 0;
        rst = 1; if_valid = 0; if_instr = 0; if_pc = 0; id_flush = 0; ex_ready = 1;
        wb_wr_en = 0; wb_wr_addr = 0; wb_wr_data = 0;
        @(posedge clk);
        #1;
        // Reset is held while every register gets a known value
        for (int unsigned k = 1; k < 32; k++)
            step(1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 1'b1, 5'(k), $urandom, 1'b1);

        // ADD x3,x1,x2 then SUB x4,x5,x6
        send(enc(7'h00, 5'd2, 5'd1, 3'd0, 5'd3, 7'h33), 1'b1);
        send(enc(7'h20, 5'd6, 5'd5, 3'd0, 5'd4, 7'h33), 1'b1);
        idle(1'b1);

        // WB bypass into ADDI x1,x5,0; then a write to x0 stays invisible
        step(1'b1, enc(7'h00, 5'd0, 5'd5, 3'd0, 5'd1, 7'h13), pc_ctr, 1'b0, 1'b1,
             1'b1, 5'd5, 32'hDEAD_BEEF, 1'b0);
        check("bypass_rs1", ex_rs1_data, 32'hDEAD_BEEF);
        step(1'b1, enc(7'h00, 5'd0, 5'd0, 3'd0, 5'd1, 7'h13), pc_ctr, 1'b0, 1'b1,
             1'b1, 5'd0, 32'h1234_5678, 1'b0);
        check("x0_reads_zero", ex_rs1_data, 32'h0);

        // LW x14,8(x15) then dependent ADD x1,x14,x2: exactly one bubble
        send(enc(7'h00, 5'd8, 5'd15, 3'd2, 5'd14, 7'h03), 1'b1);
        send(enc(7'h00, 5'd2, 5'd14, 3'd0, 5'd1, 7'h33), 1'b1);

        // LW held for 3 cycles by EX backpressure
        send(enc(7'h00, 5'd8, 5'd15, 3'd2, 5'd14, 7'h03), 1'b1);
        for (int unsigned k = 0; k < 3; k++)
            step(1'b1, enc(7'h00, 5'd2, 5'd1, 3'd0, 5'd7, 7'h33), pc_ctr, 1'b0, 1'b0,
                 1'b0, 5'd0, 32'h0, 1'b0);
        send(enc(7'h00, 5'd2, 5'd1, 3'd0, 5'd7, 7'h33), 1'b1);

        // Flush with SW presented while EX stalls
        send(enc(7'h00, 5'd8, 5'd15, 3'd2, 5'd14, 7'h03), 1'b1);
        step(1'b1, enc(7'h00, 5'd3, 5'd2, 3'd2, 5'd4, 7'h23), pc_ctr, 1'b1, 1'b0,
             1'b0, 5'd0, 32'h0, 1'b0);
        idle(1'b1);

        // Illegal opcode, then a stall followed by a mid-stream reset
        send(32'hABCD_E07F, 1'b1);
        send(enc(7'h00, 5'd8, 5'd15, 3'd2, 5'd14, 7'h03), 1'b1);
        send(enc(7'h00, 5'd2, 5'd14, 3'd0, 5'd1, 7'h33), 1'b1);
        step(1'b1, enc(7'h00, 5'd2, 5'd1, 3'd0, 5'd3, 7'h33), pc_ctr, 1'b0, 1'b1,
             1'b0, 5'd0, 32'h0, 1'b1);
        idle(1'b1);

        // Random traffic; an unaccepted instruction stays presented until taken
        pv = 0; pins = 0; ppc = 0;
        consumed = 1'b1;
        for (int unsigned k = 0; k < 3000; k++) begin
            if (consumed || !pv) begin
                pv   = ($urandom_range(0, 7) != 0);
                pins = gen_instr();
                ppc  = $urandom & 32'hFFFF_FFFC;
            end
            step(pv, pins, ppc, ($urandom_range(0, 31) == 0), ($urandom_range(0, 3) != 0),
                 1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), $urandom,
                 ($urandom_range(0, 255) == 0));
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
